alu_seq_core: RTL and testbench
===============================

// Module: alu_seq_core
// PURPOSE
//  Parametrised, clocked successor to the board-level 8-bit ALU datapath.
//  Accepts one operation per START with operands A and B. Single-cycle arithmetic, logic and compare ops complete in 1 cycle.
//  Multiply and multiply-accumulate (MAC) complete in WIDTH cycles via an iterative shift-add. Work is tracked with a BUSY/DONE handshake and NZCV flags.
//  Sits between the switch-decode logic and the existing LED/7-segment output path, which consumes RESULT.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be >= 2. RESULT and ACC are 2*WIDTH wide.
// PORTS
//  CLOCK   in   1        single system clock, rising edge
//  RESET   in   1        synchronous, active-high
//  START   in   1        request; sampled only when the core is ready (state IDLE or DONE)
//  MODE    in   2        0 arith, 1 logic, 2 compare, 3 multi-cycle
//  OP      in   2        operation select within MODE
//  A, B    in   WIDTH    operands; captured at the accepting edge
//  BUSY    out  1        high while a multi-cycle op is executing
//  DONE    out  1        one-cycle pulse: RESULT and FLAGS are valid
//  RESULT  out  2*WIDTH  registered result, held until the next accepted START
//  FLAGS   out  4        {N,Z,C,V}, registered alongside RESULT
// BEHAVIOUR
//  Reset: RESULT=0, FLAGS=0, BUSY=0, DONE=0, ACC=0, carry register=0, state=IDLE.
//  - RESET wins over all other inputs.
//  - RESET during MUL aborts the op: no DONE pulse, ACC unchanged by the aborted op is not required (ACC clears to 0).
//  FSM states: IDLE, MUL, DONE.
//  - IDLE/DONE + START with MODE!=3, or MODE 3 with OP 2/3 -> DONE at the next edge (latency 1).
//  - IDLE/DONE + START with MODE3 and OP 0/1 -> MUL; cnt=0; BUSY=1 from the next cycle.
//  - MUL: one multiplier bit per edge. After WIDTH edges, RESULT and FLAGS are written, state -> DONE, BUSY=0.
//  - DONE lasts exactly 1 cycle, then returns to IDLE. START in DONE is accepted, so back-to-back ops have no bubble.
//  - START while BUSY is ignored. Operands in flight are unaffected.
//  MODE0 ops:
//  - OP0 A+B; OP1 A-B; OP2 -A (0-A).
//  - OP3 A+B+Creg (ADC). Creg is the C flag from the last completed op.
//  - C = carry-out on add, or borrow (A<B unsigned) on sub/neg.
//  - V = signed overflow.
//  - The WIDTH-bit result is zero-extended into RESULT.
//  MODE1 ops: OP0 AND, OP1 OR, OP2 XOR, OP3 NOT A. C=V=0.
//  MODE2 ops: RESULT = 1 or 0.
//  - OP0 A==B; OP1 A>B unsigned; OP2 A<B unsigned; OP3 A<B signed.
//  - N=C=V=0.
//  MODE3 ops:
//  - OP0 MUL: RESULT = A*B unsigned, full 2*WIDTH bits. C = |RESULT[2W-1:W]. V=0.
//  - OP1 MAC: ACC <= ACC + A*B, modulo 2^(2W). RESULT = new ACC. C = carry-out of the accumulate. V=0.
//  - OP2 RDACC: RESULT = ACC. C=V=0.
//  - OP3 CLRACC: ACC=0, RESULT=0.
//  Flags: Z = (RESULT==0) over all 2*WIDTH bits.
//  - N = RESULT[WIDTH-1] for MODE0/1, RESULT[2W-1] for MODE3, 0 for MODE2.
//  Creg updates only on DONE.
// STRUCTURE
//  Shared package alu_defs:
//  - MODE_* / OP_* localparams and state encodings.
//  - Flag bit indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
//  Sub-module shift_add_mult #(WIDTH):
//  - Ports: CLOCK, RESET, load, A, B, busy, done, product.
//  - Holds the iteration counter ($clog2(WIDTH+1) bits) and partial product.
//  The top owns the FSM, the single-cycle datapath, ACC, Creg and the flag logic.
// TESTING (WIDTH=8)
//  1. RESET held 2 cycles, then released.
//     -> RESULT=0, FLAGS=0, BUSY=0, DONE=0.
//  2. MODE0 OP0 A=F0 B=20; then OP3 A=00 B=00.
//     -> First: RESULT=0010, C=1, DONE 1 cycle after START. ADC gives RESULT=0001.
//  3. MODE0 OP1 A=7F B=FF.
//     -> RESULT=0080; N=1, V=1, C=1, Z=0.
//  4. MODE3 OP0 A=FF B=FF.
//     -> BUSY high 8 cycles, then DONE; RESULT=FE01, C=1, N=1.
//     -> START pulses during BUSY are ignored.
//  5. CLRACC; MAC 03*04; MAC 05*06; RDACC.
//     -> RESULT = 000C, then 002A, then 002A; Z=1 after CLRACC.
//  6. RESET asserted on the 3rd MUL cycle.
//     -> Next cycle BUSY=0, DONE never pulses, RESULT=0.
//     -> A subsequent MODE2 OP3 A=80 B=01 gives RESULT=0001.

Source files
------------

// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared mode/op codes, FSM encodings and flag indices for alu_seq_core
package alu_defs;

    localparam logic [1:0] MODE_ARITH = 2'd0;
    localparam logic [1:0] MODE_LOGIC = 2'd1;
    localparam logic [1:0] MODE_CMP   = 2'd2;
    localparam logic [1:0] MODE_MULTI = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_NEG = 2'd2;
    localparam logic [1:0] OP_ADC = 2'd3;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    localparam logic [1:0] OP_EQ  = 2'd0;
    localparam logic [1:0] OP_GTU = 2'd1;
    localparam logic [1:0] OP_LTU = 2'd2;
    localparam logic [1:0] OP_LTS = 2'd3;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MAC    = 2'd1;
    localparam logic [1:0] OP_RDACC  = 2'd2;
    localparam logic [1:0] OP_CLRACC = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - iterative shift-add unsigned multiplier, one multiplier bit per clock
module shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt;
    logic               running;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] next_partial;

    // product is combinational so the owner can commit it on the same edge as the last bit
    assign next_partial = mplier[0] ? partial + mcand : partial;
    assign product      = next_partial;
    assign busy         = running;
    assign done         = running && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            partial <= '0;
            mplier  <= '0;
        end else if (load) begin
            running <= 1'b1;
            cnt     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            partial <= '0;
            mplier  <= b;
        end else if (running) begin
            partial <= next_partial;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - clocked ALU: single-cycle arith/logic/compare, iterative MUL/MAC, NZCV flags
module alu_seq_core
    import alu_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         flags
);

    localparam int MSB = WIDTH - 1;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic               creg;
    logic               pend_mac;

    logic               ready;
    logic               is_mult;
    logic               mult_done;
    logic [2*WIDTH-1:0] mult_product;

    logic [WIDTH:0]     ext;
    logic [2*WIDTH-1:0] sc_result;
    logic [3:0]         sc_flags;
    logic [2*WIDTH:0]   mac_sum;
    logic [2*WIDTH-1:0] mul_result;
    logic [3:0]         mul_flags;

    assign ready   = (state != ST_MUL);
    assign is_mult = (mode == MODE_MULTI) && !op[1];
    assign done    = (state == ST_DONE);

    shift_add_mult #(.WIDTH(WIDTH)) u_mult (
        .clock   (clock),
        .reset   (reset),
        .load    (ready && start && is_mult),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (mult_done),
        .product (mult_product)
    );

    always_comb begin
        ext       = '0;
        sc_result = '0;
        sc_flags  = '0;
        case (mode)
            MODE_ARITH: begin
                case (op)
                    OP_ADD:  ext = {1'b0, a} + {1'b0, b};
                    OP_SUB:  ext = {1'b0, a} - {1'b0, b};
                    OP_NEG:  ext = {(WIDTH+1){1'b0}} - {1'b0, a};
                    default: ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, creg};
                endcase
                sc_result        = {{WIDTH{1'b0}}, ext[WIDTH-1:0]};
                // top bit of the extended difference is the borrow, same slot as the add carry
                sc_flags[FLG_C]  = ext[WIDTH];
                case (op)
                    OP_SUB:  sc_flags[FLG_V] = (a[MSB] != b[MSB]) && (ext[MSB] != a[MSB]);
                    OP_NEG:  sc_flags[FLG_V] = a[MSB] && ext[MSB];
                    default: sc_flags[FLG_V] = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
                endcase
                sc_flags[FLG_N]  = ext[MSB];
            end
            MODE_LOGIC: begin
                case (op)
                    OP_AND:  sc_result[WIDTH-1:0] = a & b;
                    OP_OR:   sc_result[WIDTH-1:0] = a | b;
                    OP_XOR:  sc_result[WIDTH-1:0] = a ^ b;
                    default: sc_result[WIDTH-1:0] = ~a;
                endcase
                sc_flags[FLG_N] = sc_result[MSB];
            end
            MODE_CMP: begin
                case (op)
                    OP_EQ:   sc_result[0] = (a == b);
                    OP_GTU:  sc_result[0] = (a > b);
                    OP_LTU:  sc_result[0] = (a < b);
                    default: sc_result[0] = ($signed(a) < $signed(b));
                endcase
            end
            default: begin
                if (op == OP_RDACC) begin
                    sc_result = acc;
                end
                sc_flags[FLG_N] = sc_result[2*WIDTH-1];
            end
        endcase
        sc_flags[FLG_Z] = (sc_result == '0);
    end

    always_comb begin
        mac_sum    = {1'b0, acc} + {1'b0, mult_product};
        mul_result = pend_mac ? mac_sum[2*WIDTH-1:0] : mult_product;
        mul_flags  = '0;
        mul_flags[FLG_N] = mul_result[2*WIDTH-1];
        mul_flags[FLG_Z] = (mul_result == '0);
        mul_flags[FLG_C] = pend_mac ? mac_sum[2*WIDTH] : |mult_product[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            result   <= '0;
            flags    <= '0;
            acc      <= '0;
            creg     <= 1'b0;
            pend_mac <= 1'b0;
        end else begin
            case (state)
                ST_MUL: begin
                    if (mult_done) begin
                        result <= mul_result;
                        flags  <= mul_flags;
                        creg   <= mul_flags[FLG_C];
                        if (pend_mac) begin
                            acc <= mac_sum[2*WIDTH-1:0];
                        end
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    if (start && is_mult) begin
                        pend_mac <= (op == OP_MAC);
                        state    <= ST_MUL;
                    end else if (start) begin
                        result <= sc_result;
                        flags  <= sc_flags;
                        creg   <= sc_flags[FLG_C];
                        if (mode == MODE_MULTI && op == OP_CLRACC) begin
                            acc <= '0;
                        end
                        state  <= ST_DONE;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - scoreboard bench for alu_seq_core at WIDTH=8
module tb_alu_seq_core;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    logic [19:0] sb_q[$];
    int          acc_m = 0;
    int          c_m   = 0;

    alu_seq_core #(.WIDTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_expect(input logic [1:0] m, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int r;
        int sr;
        int sx;
        int sy;
        int xi;
        int yi;
        logic [15:0] res;
        logic n, c, v;
        xi  = int'(x);
        yi  = int'(y);
        sx  = (xi >= 128) ? xi - 256 : xi;
        sy  = (yi >= 128) ? yi - 256 : yi;
        r   = 0;
        sr  = 0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        n   = 1'b0;
        case (m)
            2'd0: begin
                case (o)
                    2'd0: begin r = xi + yi;       sr = sx + sy;       c = (r > 255); end
                    2'd1: begin r = xi - yi;       sr = sx - sy;       c = (xi < yi); end
                    2'd2: begin r = 0 - xi;        sr = 0 - sx;        c = (xi != 0); end
                    default: begin r = xi + yi + c_m; sr = sx + sy + c_m; c = (r > 255); end
                endcase
                res = 16'(r & 255);
                v   = (sr > 127) || (sr < -128);
                n   = res[7];
            end
            2'd1: begin
                case (o)
                    2'd0: res = 16'(xi & yi);
                    2'd1: res = 16'(xi | yi);
                    2'd2: res = 16'(xi ^ yi);
                    default: res = 16'(255 - xi);
                endcase
                n = res[7];
            end
            2'd2: begin
                case (o)
                    2'd0: res = 16'(xi == yi);
                    2'd1: res = 16'(xi > yi);
                    2'd2: res = 16'(xi < yi);
                    default: res = 16'(sx < sy);
                endcase
            end
            default: begin
                case (o)
                    2'd0: begin res = 16'(xi * yi); c = (res[15:8] != 0); end
                    2'd1: begin
                        r     = acc_m + xi * yi;
                        c     = (r > 65535);
                        acc_m = r & 65535;
                        res   = 16'(acc_m);
                    end
                    2'd2: res = 16'(acc_m);
                    default: begin acc_m = 0; res = '0; end
                endcase
                n = res[15];
            end
        endcase
        c_m = int'(c);
        sb_q.push_back({n, (res == 16'h0), c, v, res});
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [1:0] o,
                          input logic [7:0] x, input logic [7:0] y, input int lat, input bit poke);
        int cycles;
        int busy_cycles;
        logic [19:0] exp;
        @(negedge clock);
        mode  = m;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        push_expect(m, o, x, y);
        @(posedge clock);
        #1;
        start       = 1'b0;
        cycles      = 1;
        busy_cycles = 0;
        while (!done && cycles < 30) begin
            if (busy) busy_cycles++;
            if (poke) begin
                @(negedge clock);
                mode  = 2'd0;
                op    = 2'd0;
                a     = 8'h11;
                b     = 8'h22;
                start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
            end else begin
                @(posedge clock);
                #1;
            end
            cycles++;
        end
        check({tag, "_lat"}, cycles, lat);
        if (lat > 1) check({tag, "_busy"}, busy_cycles, 8);
        exp = sb_q.pop_front();
        check({tag, "_res"}, result, exp[15:0]);
        check({tag, "_flg"}, flags, exp[19:16]);
    endtask

    initial begin
        int dcount;
        logic [1:0] rm;
        reset = 1'b1;
        start = 1'b0;
        mode  = '0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", result, 16'h0);
        check("rst_flags", flags, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        run_op("add_f0_20", 2'd0, 2'd0, 8'hF0, 8'h20, 1, 1'b0);
        check("add_c", flags[1], 1'b1);
        run_op("adc_00", 2'd0, 2'd3, 8'h00, 8'h00, 1, 1'b0);
        check("adc_res", result, 16'h0001);
        @(posedge clock);
        #1;
        check("done_pulse_1cyc", done, 1'b0);

        run_op("sub_7f_ff", 2'd0, 2'd1, 8'h7F, 8'hFF, 1, 1'b0);
        check("sub_nzcv", flags, 4'b1011);

        run_op("mul_ff_ff", 2'd3, 2'd0, 8'hFF, 8'hFF, 9, 1'b1);
        check("mul_res", result, 16'hFE01);
        dcount = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done) dcount++;
        end
        check("no_stray_done", dcount, 0);

        run_op("clracc", 2'd3, 2'd3, 8'h12, 8'h34, 1, 1'b0);
        check("clracc_z", flags[2], 1'b1);
        run_op("mac_3_4", 2'd3, 2'd1, 8'h03, 8'h04, 9, 1'b0);
        run_op("mac_5_6", 2'd3, 2'd1, 8'h05, 8'h06, 9, 1'b0);
        run_op("rdacc", 2'd3, 2'd2, 8'h00, 8'h00, 1, 1'b0);
        check("rdacc_res", result, 16'h002A);
        run_op("neg_80", 2'd0, 2'd2, 8'h80, 8'h00, 1, 1'b0);
        run_op("mac_wrap", 2'd3, 2'd1, 8'hFF, 8'hFF, 9, 1'b0);
        run_op("mac_wrap2", 2'd3, 2'd1, 8'hFF, 8'hFF, 9, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rm = 2'($urandom_range(0, 2));
            run_op("rand", rm, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1, 1'b0);
        end

        @(negedge clock);
        mode  = 2'd3;
        op    = 2'd0;
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        acc_m = 0;
        c_m   = 0;
        dcount = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (done) dcount++;
        end
        check("abort_no_done", dcount, 0);
        run_op("rdacc_after_rst", 2'd3, 2'd2, 8'h00, 8'h00, 1, 1'b0);
        run_op("lts_80_01", 2'd2, 2'd3, 8'h80, 8'h01, 1, 1'b0);
        check("lts_res", result, 16'h0001);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
